// File: rtl/branch_pred_pkg.sv
// Shared types and constants for the branch trace driver and the perceptron
// predictor pin mapping it feeds.
package branch_pred_pkg;

    typedef enum logic [2:0] {
        WAIT_MEM   = 3'd0,
        IDLE       = 3'd1,
        PRESENT    = 3'd2,
        WAIT_PRED  = 3'd3,
        WAIT_TRAIN = 3'd4,
        REPORT     = 3'd5,
        GAP        = 3'd6,
        ERROR      = 3'd7
    } state_e;

    // Predictor uio_in bit positions driven by this block
    localparam int UIO_NEW_DATA_AVAIL   = 0;
    localparam int UIO_DIRECTION_TRUTH  = 1;
    localparam int UIO_HISTORY_REQUEST  = 7;

    // Predictor uo_out bit positions consumed by this block
    localparam int UO_PRED_READY        = 0;
    localparam int UO_PREDICTION        = 1;
    localparam int UO_TRAINING_DONE     = 2;
    localparam int UO_MEM_RESET_DONE    = 3;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int DEFAULT_GAP_CYCLES     = 2;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign q = cnt_q;

endmodule

// File: rtl/branch_trace_driver.sv
// Feeds one branch record at a time into the perceptron predictor, waits for
// its prediction/training handshakes and scores the result.
module branch_trace_driver
    import branch_pred_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    // Record port: a record transfers on a cycle where rec_valid && rec_ready;
    // rec_pc_byte/rec_taken must be stable while rec_valid is high, and
    // rec_ready never depends combinationally on rec_valid.
    input  logic             rec_valid,
    output logic             rec_ready,
    input  logic [7:0]       rec_pc_byte,
    input  logic             rec_taken,
    output logic             new_data_avail,
    output logic             direction_ground_truth,
    output logic [7:0]       inst_lowest_byte,
    output logic             history_buffer_request,
    input  logic             pred_ready,
    input  logic             prediction,
    input  logic             training_done,
    input  logic             mem_reset_done,
    output logic             res_valid,
    output logic             res_prediction,
    output logic             res_correct,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count,
    output logic             err,
    output state_e           dbg_state
);

    localparam int TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LIM = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] GAP_LIM     = TMR_W'(GAP_CYCLES);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d, tmr_next;
    logic [7:0]       pc_q, pc_d;
    logic             taken_q, taken_d;
    logic             pred_q, pred_d;
    logic             rec_ready_q, rec_ready_d;
    logic             nda_q, nda_d;
    logic             res_valid_q, res_valid_d;
    logic             res_pred_q, res_pred_d;
    logic             res_correct_q, res_correct_d;
    logic             err_q, err_d;
    logic             report_entry;
    logic             mispredict;

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        pc_d          = pc_q;
        taken_d       = taken_q;
        pred_d        = pred_q;
        res_pred_d    = res_pred_q;
        res_correct_d = res_correct_q;
        tmr_next      = tmr_q + TMR_W'(1);

        case (state_q)
            WAIT_MEM: begin
                if (mem_reset_done) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (rec_valid && rec_ready_q) begin
                    pc_d    = rec_pc_byte;
                    taken_d = rec_taken;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                state_d = WAIT_PRED;
                tmr_d   = '0;
            end
            WAIT_PRED: begin
                if (pred_ready) begin
                    pred_d = prediction;
                    if (training_done) begin
                        state_d = REPORT;
                    end else begin
                        state_d = WAIT_TRAIN;
                        tmr_d   = '0;
                    end
                end else if (tmr_next == TIMEOUT_LIM) begin
                    state_d = ERROR;
                end else begin
                    tmr_d = tmr_next;
                end
            end
            WAIT_TRAIN: begin
                if (training_done) begin
                    state_d = REPORT;
                end else if (tmr_next == TIMEOUT_LIM) begin
                    state_d = ERROR;
                end else begin
                    tmr_d = tmr_next;
                end
            end
            REPORT: begin
                state_d = GAP;
                tmr_d   = '0;
            end
            GAP: begin
                if (tmr_next == GAP_LIM) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_next;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = WAIT_MEM;
            end
        endcase

        // Scoring uses pred_d so a prediction arriving together with
        // training_done is scored in the same transition.
        report_entry = (state_d == REPORT) && (state_q != REPORT);
        mispredict   = report_entry && (pred_d != taken_q);
        if (report_entry) begin
            res_pred_d    = pred_d;
            res_correct_d = (pred_d == taken_q);
        end

        // Outputs are registered versions of what the next state implies.
        rec_ready_d = (state_d == IDLE);
        nda_d       = (state_d == PRESENT) || (state_d == WAIT_PRED) ||
                      (state_d == WAIT_TRAIN) || (state_d == REPORT);
        res_valid_d = report_entry;
        err_d       = (state_d == ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_MEM;
            tmr_q         <= '0;
            pc_q          <= '0;
            taken_q       <= 1'b0;
            pred_q        <= 1'b0;
            rec_ready_q   <= 1'b0;
            nda_q         <= 1'b0;
            res_valid_q   <= 1'b0;
            res_pred_q    <= 1'b0;
            res_correct_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            pc_q          <= pc_d;
            taken_q       <= taken_d;
            pred_q        <= pred_d;
            rec_ready_q   <= rec_ready_d;
            nda_q         <= nda_d;
            res_valid_q   <= res_valid_d;
            res_pred_q    <= res_pred_d;
            res_correct_q <= res_correct_d;
            err_q         <= err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk (clk),
        .clr (rst),
        .inc (report_entry),
        .q   (branch_count)
    );

    sat_counter #(.W(CNT_W)) u_mispredict_cnt (
        .clk (clk),
        .clr (rst),
        .inc (mispredict),
        .q   (mispredict_count)
    );

    assign rec_ready              = rec_ready_q;
    assign new_data_avail         = nda_q;
    assign direction_ground_truth = taken_q;
    assign inst_lowest_byte       = pc_q;
    assign history_buffer_request = 1'b0;
    assign res_valid              = res_valid_q;
    assign res_prediction         = res_pred_q;
    assign res_correct            = res_correct_q;
    assign err                    = err_q;
    assign dbg_state              = state_q;

endmodule

// File: tb/tb_branch_trace_driver.sv
// Directed bench for branch_trace_driver: one default instance plus a CNT_W=2
// instance sharing the same stimulus to exercise counter saturation.
module tb_branch_trace_driver;
  import branch_pred_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       rec_valid, rec_taken, pred_ready, prediction, training_done, mem_reset_done;
  logic [7:0] rec_pc_byte;

  logic        a_rec_ready, a_nda, a_dgt, a_hbr, a_res_valid, a_res_pred, a_res_correct, a_err;
  logic [7:0]  a_ilb;
  logic [15:0] a_bcnt, a_mcnt;
  state_e      a_state;

  logic        b_rec_ready, b_nda, b_dgt, b_hbr, b_res_valid, b_res_pred, b_res_correct, b_err;
  logic [7:0]  b_ilb;
  logic [1:0]  b_bcnt, b_mcnt;
  state_e      b_state;

  branch_trace_driver u_dut (
    .clk(clk), .rst(rst),
    .rec_valid(rec_valid), .rec_ready(a_rec_ready), .rec_pc_byte(rec_pc_byte), .rec_taken(rec_taken),
    .new_data_avail(a_nda), .direction_ground_truth(a_dgt), .inst_lowest_byte(a_ilb),
    .history_buffer_request(a_hbr),
    .pred_ready(pred_ready), .prediction(prediction), .training_done(training_done),
    .mem_reset_done(mem_reset_done),
    .res_valid(a_res_valid), .res_prediction(a_res_pred), .res_correct(a_res_correct),
    .branch_count(a_bcnt), .mispredict_count(a_mcnt), .err(a_err), .dbg_state(a_state)
  );

  branch_trace_driver #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .rec_valid(rec_valid), .rec_ready(b_rec_ready), .rec_pc_byte(rec_pc_byte), .rec_taken(rec_taken),
    .new_data_avail(b_nda), .direction_ground_truth(b_dgt), .inst_lowest_byte(b_ilb),
    .history_buffer_request(b_hbr),
    .pred_ready(pred_ready), .prediction(prediction), .training_done(training_done),
    .mem_reset_done(mem_reset_done),
    .res_valid(b_res_valid), .res_prediction(b_res_pred), .res_correct(b_res_correct),
    .branch_count(b_bcnt), .mispredict_count(b_mcnt), .err(b_err), .dbg_state(b_state)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: {inst_lowest_byte, res_correct} expected at each res_valid pulse
  logic [8:0] exp_q[$];

  always @(negedge clk) begin
    if (a_res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check_eq("sb_result", {23'd0, a_ilb, a_res_correct}, {23'd0, e});
      end
    end
  end

  // Gap monitor: shortest low run of new_data_avail before a rising edge
  int low_run  = 0;
  int min_low  = 1000;
  always @(negedge clk) begin
    if (a_nda === 1'b1) begin
      if (low_run > 0 && low_run < min_low) min_low = low_run;
      low_run = 0;
    end else begin
      low_run++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_a_outs"}, {24'd0, a_rec_ready, a_nda, a_dgt, a_hbr, a_res_valid, a_res_pred,
                                a_res_correct, a_err}, 32'd0);
    check_eq({tag, "_a_ilb"}, {24'd0, a_ilb}, 32'd0);
    check_eq({tag, "_a_cnts"}, {a_bcnt, a_mcnt}, 32'd0);
    check_eq({tag, "_a_state"}, 32'(a_state), 32'(WAIT_MEM));
    check_eq({tag, "_b_outs"}, {20'd0, b_rec_ready, b_nda, b_dgt, b_hbr, b_res_valid, b_res_pred,
                                b_res_correct, b_err, b_bcnt, b_mcnt}, 32'd0);
  endtask

  task automatic send_record(input logic [7:0] pc, input logic taken, input string tag);
    int n;
    n = 0;
    while (a_rec_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check_eq({tag, "_rec_ready"}, {31'd0, a_rec_ready}, 32'd1);
    rec_valid   = 1'b1;
    rec_pc_byte = pc;
    rec_taken   = taken;
    step();
    rec_valid   = 1'b0;
    check_eq({tag, "_nda_rise"}, {31'd0, a_nda}, 32'd1);
    check_eq({tag, "_ilb"}, {24'd0, a_ilb}, {24'd0, pc});
    check_eq({tag, "_dgt"}, {31'd0, a_dgt}, {31'd0, taken});
  endtask

  // Predictor model: prediction pred_dly cycles after the record, training
  // train_dly cycles after that (0 = same cycle as pred_ready).
  task automatic predictor(input logic pred, input int pred_dly, input int train_dly);
    repeat (pred_dly) step();
    pred_ready    = 1'b1;
    prediction    = pred;
    training_done = (train_dly == 0);
    step();
    pred_ready    = 1'b0;
    training_done = 1'b0;
    if (train_dly > 0) begin
      repeat (train_dly - 1) step();
      training_done = 1'b1;
      step();
      training_done = 1'b0;
    end
  endtask

  task automatic run_branch(input logic [7:0] pc, input logic taken, input logic pred,
                            input int pred_dly, input int train_dly,
                            input int exp_bcnt, input int exp_mcnt, input string tag);
    exp_q.push_back({pc, pred == taken});
    send_record(pc, taken, tag);
    predictor(pred, pred_dly, train_dly);
    check_eq({tag, "_state_report"}, 32'(a_state), 32'(REPORT));
    check_eq({tag, "_res_valid"}, {31'd0, a_res_valid}, 32'd1);
    check_eq({tag, "_res_pred"}, {31'd0, a_res_pred}, {31'd0, pred});
    check_eq({tag, "_res_correct"}, {31'd0, a_res_correct}, {31'd0, pred == taken});
    check_eq({tag, "_bcnt"}, {16'd0, a_bcnt}, 32'(exp_bcnt));
    check_eq({tag, "_mcnt"}, {16'd0, a_mcnt}, 32'(exp_mcnt));
    step();
    check_eq({tag, "_res_valid_drop"}, {31'd0, a_res_valid}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] pc_tab [10] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87, 8'h98, 8'hA9};
  logic       tk_tab [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int exp_mis;
    rst = 1'b1; rec_valid = 1'b0; rec_pc_byte = '0; rec_taken = 1'b0;
    pred_ready = 1'b0; prediction = 1'b0; training_done = 1'b0; mem_reset_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Startup: memory reset not yet done
    repeat (20) step();
    check_eq("startup_rec_ready_low", {31'd0, a_rec_ready}, 32'd0);
    check_eq("startup_state", 32'(a_state), 32'(WAIT_MEM));
    mem_reset_done = 1'b1;
    step();
    check_eq("startup_rec_ready_high", {31'd0, a_rec_ready}, 32'd1);

    // Correct prediction
    run_branch(8'hA5, 1'b1, 1'b1, 3, 2, 1, 0, "correct");
    repeat (4) step();
    check_eq("held_ilb", {24'd0, a_ilb}, 32'hA5);
    check_eq("held_dgt", {31'd0, a_dgt}, 32'd1);

    // Ten back-to-back records, predictor always says not-taken
    min_low = 1000;
    exp_mis = 0;
    for (int i = 0; i < 10; i++) begin
      exp_mis += int'(tk_tab[i]);
      run_branch(pc_tab[i], tk_tab[i], 1'b0, 1 + (i % 3), 1 + (i % 2), i + 2, exp_mis, "b2b");
    end
    check_eq("b2b_bcnt_final", {16'd0, a_bcnt}, 32'd11);
    check_eq("b2b_mcnt_final", {16'd0, a_mcnt}, 32'd4);
    check_eq("gap_min_ge_2", {31'd0, min_low >= 2}, 32'd1);
    check_eq("sat_bcnt", {30'd0, b_bcnt}, 32'd3);
    check_eq("sat_mcnt", {30'd0, b_mcnt}, 32'd3);

    // Simultaneous pred_ready and training_done
    run_branch(8'h3C, 1'b0, 1'b0, 2, 0, 12, 4, "simul");
    check_eq("simul_sat_bcnt", {30'd0, b_bcnt}, 32'd3);

    // Reset while waiting for training
    send_record(8'h77, 1'b1, "midrst");
    repeat (2) step();
    pred_ready = 1'b1;
    prediction = 1'b1;
    step();
    pred_ready = 1'b0;
    check_eq("midrst_state_train", 32'(a_state), 32'(WAIT_TRAIN));
    rst = 1'b1;
    mem_reset_done = 1'b0;
    step();
    check_all_zero("midrst");
    rst = 1'b0;
    mem_reset_done = 1'b1;
    step();
    check_eq("midrst_rec_ready", {31'd0, a_rec_ready}, 32'd1);

    // Timeout: predictor never answers
    send_record(8'h5A, 1'b0, "tmo");
    repeat (64) step();
    check_eq("tmo_err_early", {31'd0, a_err}, 32'd0);
    check_eq("tmo_state_wait", 32'(a_state), 32'(WAIT_PRED));
    step();
    check_eq("tmo_err", {31'd0, a_err}, 32'd1);
    check_eq("tmo_nda", {31'd0, a_nda}, 32'd0);
    check_eq("tmo_rec_ready", {31'd0, a_rec_ready}, 32'd0);
    rec_valid = 1'b1;
    pred_ready = 1'b1;
    training_done = 1'b1;
    repeat (5) step();
    check_eq("tmo_err_sticky", {31'd0, a_err}, 32'd1);
    check_eq("tmo_state_sticky", 32'(a_state), 32'(ERROR));
    check_eq("tmo_rec_ready_sticky", {31'd0, a_rec_ready}, 32'd0);
    rec_valid = 1'b0;
    pred_ready = 1'b0;
    training_done = 1'b0;
    rst = 1'b1;
    mem_reset_done = 1'b0;
    step();
    check_all_zero("tmo_rst");
    rst = 1'b0;

    step();
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
